csr_trap_ctrl: RTL and testbench

// Trap sequencer upstream of the CSR register file; drives its single write port.
// On ecall it writes mepc, mcause and mstatus in that order, then redirects fetch to mtvec.
// On mret it restores mstatus, then redirects fetch to mepc.
// The pipeline is held (stall) for the whole sequence; flush and redirect are pulsed at the end.

---
 rtl/csr_trap_ctrl_if.sv | 30 +++
 rtl/csr_trap_ctrl.sv | 136 +++++++++++++
 tb/tb_csr_trap_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_ctrl_if.sv
// rtl/csr_trap_ctrl_if.sv - trap request, CSR write port and fetch redirect bundle
interface csr_trap_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              ecall_valid;
  logic [DATA_W-1:0] ecall_pc;
  logic              mret_valid;
  logic [DATA_W-1:0] csr_mtvec;
  logic [DATA_W-1:0] csr_mepc;
  logic [DATA_W-1:0] csr_mstatus;
  logic              csr_we;
  logic [ADDR_W-1:0] csr_addr_w;
  logic [DATA_W-1:0] csr_wdata;
  logic              stall;
  logic              busy;
  logic              flush;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;

  modport master (
    output ecall_valid, ecall_pc, mret_valid, csr_mtvec, csr_mepc, csr_mstatus,
    input  csr_we, csr_addr_w, csr_wdata, stall, busy, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  ecall_valid, ecall_pc, mret_valid, csr_mtvec, csr_mepc, csr_mstatus,
    output csr_we, csr_addr_w, csr_wdata, stall, busy, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - ecall/mret trap sequencer driving the CSR write port and fetch redirect
module csr_trap_ctrl #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 12,
  parameter logic [DATA_W-1:0] ECALL_CAUSE  = 32'd11,
  parameter logic [ADDR_W-1:0] MSTATUS_ADDR = 12'h300,
  parameter logic [ADDR_W-1:0] MEPC_ADDR    = 12'h341,
  parameter logic [ADDR_W-1:0] MCAUSE_ADDR  = 12'h342
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  csr_trap_ctrl_if.slave    bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] E_EPC   = 3'd1;
  localparam logic [2:0] E_CAUSE = 3'd2;
  localparam logic [2:0] E_STAT  = 3'd3;
  localparam logic [2:0] E_REDIR = 3'd4;
  localparam logic [2:0] M_STAT  = 3'd5;
  localparam logic [2:0] M_REDIR = 3'd6;

  logic [2:0]        r_state;
  logic              r_csr_we;
  logic [ADDR_W-1:0] r_csr_addr;
  logic [DATA_W-1:0] r_csr_wdata;
  logic              r_busy;
  logic              r_redirect;
  logic [DATA_W-1:0] r_redirect_pc;

  logic [2:0]        w_next;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_redirect;
  logic [DATA_W-1:0] w_redirect_pc;
  logic [DATA_W-1:0] w_mstatus_trap;
  logic [DATA_W-1:0] w_mstatus_ret;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.ecall_valid)     w_next = E_EPC;
        else if (bus.mret_valid) w_next = M_STAT;
      end
      E_EPC:   w_next = E_CAUSE;
      E_CAUSE: w_next = E_STAT;
      E_STAT:  w_next = E_REDIR;
      M_STAT:  w_next = M_REDIR;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_mstatus_trap        = bus.csr_mstatus;
    w_mstatus_trap[7]     = bus.csr_mstatus[3];
    w_mstatus_trap[3]     = 1'b0;
    w_mstatus_trap[12:11] = 2'b11;
    w_mstatus_ret         = bus.csr_mstatus;
    w_mstatus_ret[3]      = bus.csr_mstatus[7];
    w_mstatus_ret[7]      = 1'b1;
    w_mstatus_ret[12:11]  = 2'b11;
  end

  // Outputs are registered from the next state, so each state's values appear
  // in the cycle the state is held and no input reaches an output combinationally.
  always_comb begin
    w_we          = 1'b0;
    w_addr        = '0;
    w_wdata       = '0;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    case (w_next)
      E_EPC: begin
        w_we    = 1'b1;
        w_addr  = MEPC_ADDR;
        w_wdata = bus.ecall_pc;
      end
      E_CAUSE: begin
        w_we    = 1'b1;
        w_addr  = MCAUSE_ADDR;
        w_wdata = ECALL_CAUSE;
      end
      E_STAT: begin
        w_we    = 1'b1;
        w_addr  = MSTATUS_ADDR;
        w_wdata = w_mstatus_trap;
      end
      E_REDIR: begin
        w_redirect    = 1'b1;
        w_redirect_pc = bus.csr_mtvec & ({DATA_W{1'b1}} << 2);
      end
      M_STAT: begin
        w_we    = 1'b1;
        w_addr  = MSTATUS_ADDR;
        w_wdata = w_mstatus_ret;
      end
      M_REDIR: begin
        w_redirect    = 1'b1;
        w_redirect_pc = bus.csr_mepc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_csr_we      <= 1'b0;
      r_csr_addr    <= '0;
      r_csr_wdata   <= '0;
      r_busy        <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_next;
      r_csr_we      <= w_we;
      r_csr_addr    <= w_addr;
      r_csr_wdata   <= w_wdata;
      r_busy        <= (w_next != IDLE);
      r_redirect    <= w_redirect;
      r_redirect_pc <= w_redirect_pc;
    end
  end

  assign bus.csr_we         = r_csr_we;
  assign bus.csr_addr_w     = r_csr_addr;
  assign bus.csr_wdata      = r_csr_wdata;
  assign bus.busy           = r_busy;
  assign bus.stall          = r_busy;
  assign bus.flush          = r_redirect;
  assign bus.redirect_valid = r_redirect;
  assign bus.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - directed and randomized trap sequences against a trace-level model
module tb_csr_trap_ctrl;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;

  csr_trap_ctrl_if #(.DATA_W(32), .ADDR_W(12)) bus ();

  csr_trap_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t obs_now();
    obs_t o;
    o = '{we: bus.csr_we, addr: bus.csr_addr_w, wdata: bus.csr_wdata, busy: bus.busy,
          stall: bus.stall, flush: bus.flush, rv: bus.redirect_valid, rpc: bus.redirect_pc};
    return o;
  endfunction

  function automatic obs_t mk_idle();
    obs_t o;
    o = '0;
    return o;
  endfunction

  function automatic obs_t mk_wr(input logic [11:0] a, input logic [31:0] d);
    obs_t o;
    o = '0;
    o.we = 1'b1; o.addr = a; o.wdata = d; o.busy = 1'b1; o.stall = 1'b1;
    return o;
  endfunction

  function automatic obs_t mk_redir(input logic [31:0] pc);
    obs_t o;
    o = '0;
    o.busy = 1'b1; o.stall = 1'b1; o.flush = 1'b1; o.rv = 1'b1; o.rpc = pc;
    return o;
  endfunction

  // Trap entry: MPIE takes old MIE, MIE cleared, MPP forced to machine mode.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    return (ms & ~32'h0000_0088) | (((ms >> 3) & 32'd1) << 7) | 32'h0000_1800;
  endfunction

  // Return: MIE takes MPIE, MPIE set, MPP stays machine mode.
  function automatic logic [31:0] ret_mstatus(input logic [31:0] ms);
    return (ms & ~32'h0000_0088) | (((ms >> 7) & 32'd1) << 3) | 32'h0000_0080 | 32'h0000_1800;
  endfunction

  task automatic check(input string tag, input obs_t o, input obs_t e);
    n_vec++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // kind: 0 ecall, 1 mret, 2 both. junk disturbs requests/pc mid-sequence;
  // hold keeps an ecall asserted through the first flush so it is re-accepted.
  task automatic do_txn(input string name, input int kind, input logic [31:0] pc,
                        input logic [31:0] mtvec, input logic [31:0] mepc,
                        input logic [31:0] ms, input bit junk, input bit hold);
    obs_t exp_q[$];
    int   flushes;
    int   need;
    int   reps;
    reps = (hold && kind != 1) ? 2 : 1;
    for (int r = 0; r < reps; r++) begin
      if (kind != 1) begin
        exp_q.push_back(mk_wr(12'h341, pc));
        exp_q.push_back(mk_wr(12'h342, 32'd11));
        exp_q.push_back(mk_wr(12'h300, trap_mstatus(ms)));
        exp_q.push_back(mk_redir(mtvec & ~32'd3));
      end else begin
        exp_q.push_back(mk_wr(12'h300, ret_mstatus(ms)));
        exp_q.push_back(mk_redir(mepc));
      end
      exp_q.push_back(mk_idle());
    end
    exp_q.push_back(mk_idle());

    bus.csr_mtvec   = mtvec;
    bus.csr_mepc    = mepc;
    bus.csr_mstatus = ms;
    bus.ecall_pc    = pc;
    bus.ecall_valid = (kind != 1);
    bus.mret_valid  = (kind != 0);
    check({name, "_pre"}, obs_now(), mk_idle());

    flushes = 0;
    need    = reps;
    foreach (exp_q[i]) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_c%0d", name, i), obs_now(), exp_q[i]);
      if (exp_q[i].flush) begin
        flushes++;
        if (flushes >= need) begin
          bus.ecall_valid = 1'b0;
          bus.mret_valid  = 1'b0;
        end
      end else if (junk && flushes == 0) begin
        bus.ecall_pc = $urandom;
        if (kind == 1) bus.ecall_valid = 1'($urandom_range(0, 1));
        else           bus.mret_valid  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.ecall_valid = 1'b0;
    bus.mret_valid  = 1'b0;
    bus.ecall_pc    = '0;
    bus.csr_mtvec   = '0;
    bus.csr_mepc    = '0;
    bus.csr_mstatus = '0;
    #12;
    check("reset", obs_now(), mk_idle());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset", obs_now(), mk_idle());

    do_txn("t1_ecall",   0, 32'h100, 32'h170, 32'h0, 32'h1808, 1'b0, 1'b0);
    do_txn("t2_mret",    1, 32'h0,   32'h0,   32'h104, 32'h1880, 1'b0, 1'b0);
    do_txn("t3_both",    2, 32'h200, 32'h400, 32'h55C, 32'h0008, 1'b0, 1'b0);
    do_txn("t4_mtvec",   0, 32'h300, 32'h173, 32'h0, 32'h0000, 1'b0, 1'b0);
    do_txn("t5_glitch",  0, 32'h404, 32'h800, 32'h0, 32'h0088, 1'b1, 1'b0);
    do_txn("reaccept",   0, 32'h808, 32'hA01, 32'h0, 32'h1808, 1'b0, 1'b1);

    // Reset during E_CAUSE: outputs drop without waiting for a clock edge.
    bus.csr_mtvec   = 32'h170;
    bus.csr_mstatus = 32'h1808;
    bus.ecall_pc    = 32'h120;
    bus.ecall_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t6_epc", obs_now(), mk_wr(12'h341, 32'h120));
    @(posedge clk);
    #1;
    check("t6_cause", obs_now(), mk_wr(12'h342, 32'd11));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async", obs_now(), mk_idle());
    bus.ecall_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_idle0", obs_now(), mk_idle());
    @(posedge clk);
    #1;
    check("t6_idle1", obs_now(), mk_idle());

    for (int k = 0; k < 24; k++) begin
      do_txn($sformatf("rnd%0d", k), int'($urandom_range(0, 2)), $urandom, $urandom,
             $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
